// File: rtl/twenty_bit_serial_adder_pkg.sv
// Shared width and control-state encodings for the twenty-bit serial
// arithmetic family (adder and subtractor use the same definitions).
package twenty_bit_serial_adder_pkg;

    localparam int WIDTH = 20;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/twenty_bit_serial_adder_digit_adder.sv
// One DIGIT_W-bit ripple-carry slice; the serial adder reuses it once per
// digit, threading the carry through a register between cycles.
module digit_adder #(
    parameter int DIGIT_W = 4
) (
    input  logic [DIGIT_W-1:0] i_a,
    input  logic [DIGIT_W-1:0] i_b,
    input  logic               i_cin,
    output logic [DIGIT_W-1:0] o_sum,
    output logic               o_cout
);

    always_comb begin : ripple
        logic carry;
        o_sum = '0;
        carry = i_cin;
        for (int k = 0; k < DIGIT_W; k++) begin
            o_sum[k] = i_a[k] ^ i_b[k] ^ carry;
            carry    = (i_a[k] & i_b[k]) | (carry & (i_a[k] ^ i_b[k]));
        end
        o_cout = carry;
    end

endmodule

// File: rtl/twenty_bit_serial_adder.sv
// Twenty-bit adder that processes DIGIT_W bits per clock, LSB digit first,
// and publishes sum/carry atomically with a one-cycle done pulse.
module twenty_bit_serial_adder
    import twenty_bit_serial_adder_pkg::*;
#(
    parameter int DIGIT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] i0,
    input  logic [WIDTH-1:0] i1,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             busy,
    output logic             done
);

    localparam int NDIG = WIDTH / DIGIT_W;
    localparam int CW   = $clog2(NDIG + 1);

    state_t             r_state;
    state_t             w_nextState;
    logic [WIDTH-1:0]   r_opA;
    logic [WIDTH-1:0]   r_opB;
    logic [WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]   r_sum;
    logic               r_carry;
    logic               r_cout;
    logic               r_done;
    logic [CW-1:0]      r_count;
    logic               w_load;
    logic               w_step;
    logic               w_last;
    logic [DIGIT_W-1:0] w_digSum;
    logic               w_digCout;
    logic [WIDTH-1:0]   w_accNext;

    digit_adder #(
        .DIGIT_W (DIGIT_W)
    ) u_digit (
        .i_a    (r_opA[DIGIT_W-1:0]),
        .i_b    (r_opB[DIGIT_W-1:0]),
        .i_cin  (r_carry),
        .o_sum  (w_digSum),
        .o_cout (w_digCout)
    );

    // New digit enters at the top so after NDIG steps the LSB digit sits at bit 0.
    assign w_accNext = WIDTH'({w_digSum, r_acc} >> DIGIT_W);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_load      = 1'b0;
        w_step      = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_load      = 1'b1;
                    w_nextState = RUN;
                end
            end
            RUN: begin
                w_step = 1'b1;
                if (r_count == CW'(NDIG - 1)) begin
                    w_last      = 1'b1;
                    w_nextState = IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_opA   <= '0;
            r_opB   <= '0;
            r_acc   <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_done  <= 1'b0;
            r_count <= '0;
        end else begin
            r_done <= w_last;
            if (w_load) begin
                r_opA   <= i0;
                r_opB   <= i1;
                r_acc   <= '0;
                r_carry <= 1'b0;
                r_count <= '0;
            end else if (w_step) begin
                r_opA   <= r_opA >> DIGIT_W;
                r_opB   <= r_opB >> DIGIT_W;
                r_acc   <= w_accNext;
                r_carry <= w_digCout;
                r_count <= r_count + CW'(1);
                if (w_last) begin
                    r_sum  <= w_accNext;
                    r_cout <= w_digCout;
                end
            end
        end
    end

    assign s    = r_sum;
    assign cout = r_cout;
    assign busy = (r_state == RUN);
    assign done = r_done;

endmodule

// File: tb/tb_twenty_bit_serial_adder.sv
// Scoreboard bench driving three adder instances (DIGIT_W = 4, 1, 20) one
// after another with directed vectors; a negedge monitor checks every done.
module tb_twenty_bit_serial_adder;

    localparam int NDIG_L [3] = '{5, 20, 1};

    typedef struct {
        logic [20:0] res;
        int          e0;
        string       name;
    } exp_t;

    typedef struct {
        string       name;
        logic [31:0] act;
        logic [31:0] exp;
    } probe_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [2:0]  startV = 3'b000;
    logic [19:0] i0 = '0;
    logic [19:0] i1 = '0;
    logic [19:0] sV [3];
    logic        coutV [3];
    logic        busyV [3];
    logic        doneV [3];

    exp_t   scoreQ [3][$];
    probe_t probeQ [$];
    int     cycleCnt   = 0;
    int     passCount  = 0;
    int     totalCount = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    twenty_bit_serial_adder #(.DIGIT_W(4)) dut4 (
        .clk(clk), .rst(rst), .start(startV[0]), .i0(i0), .i1(i1),
        .s(sV[0]), .cout(coutV[0]), .busy(busyV[0]), .done(doneV[0])
    );

    twenty_bit_serial_adder #(.DIGIT_W(1)) dut1 (
        .clk(clk), .rst(rst), .start(startV[1]), .i0(i0), .i1(i1),
        .s(sV[1]), .cout(coutV[1]), .busy(busyV[1]), .done(doneV[1])
    );

    twenty_bit_serial_adder #(.DIGIT_W(20)) dut20 (
        .clk(clk), .rst(rst), .start(startV[2]), .i0(i0), .i1(i1),
        .s(sV[2]), .cout(coutV[2]), .busy(busyV[2]), .done(doneV[2])
    );

    // Monitor: drains direct probes, and pairs each done pulse with the oldest expectation.
    initial begin
        exp_t   e;
        probe_t p;
        forever begin
            @(negedge clk);
            while (probeQ.size() > 0) begin
                p = probeQ.pop_front();
                totalCount++;
                if (p.act == p.exp) passCount++;
                else $display("[TB] FAIL %s: got %0h, expected %0h", p.name, p.act, p.exp);
            end
            for (int l = 0; l < 3; l++) begin
                if (doneV[l]) begin
                    totalCount++;
                    if (scoreQ[l].size() == 0) begin
                        $display("[TB] FAIL lane%0d unexpected done: got s=%0h cout=%0b, expected no done",
                                 l, sV[l], coutV[l]);
                    end else begin
                        e = scoreQ[l].pop_front();
                        if ({coutV[l], sV[l]} == e.res) passCount++;
                        else $display("[TB] FAIL lane%0d %s result: got %0h, expected %0h",
                                      l, e.name, {coutV[l], sV[l]}, e.res);
                        totalCount++;
                        if (cycleCnt - e.e0 == NDIG_L[l]) passCount++;
                        else $display("[TB] FAIL lane%0d %s latency: got %0d, expected %0d",
                                      l, e.name, cycleCnt - e.e0, NDIG_L[l]);
                    end
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        probeQ.push_back('{name, act, exp});
    endtask

    // Drives one request at a negedge (start left high) and queues the model result.
    task automatic applyStimulus(input int l, input logic [19:0] a, input logic [19:0] b,
                                 input bit expectDone, input string name, output int e0);
        @(negedge clk);
        i0 = a;
        i1 = b;
        startV[l] = 1'b1;
        e0 = cycleCnt + 1;
        if (expectDone) scoreQ[l].push_back('{{1'b0, a} + {1'b0, b}, e0, name});
    endtask

    task automatic waitIdle(input int l);
        int k = 0;
        while ((busyV[l] || scoreQ[l].size() != 0) && k < 60) begin
            @(negedge clk);
            k++;
        end
        if (k >= 60) checkOutput($sformatf("lane%0d idle timeout", l), 32'd1, 32'd0);
        @(negedge clk);
    endtask

    task automatic simpleOp(input int l, input logic [19:0] a, input logic [19:0] b, input string name);
        int e0;
        applyStimulus(l, a, b, 1'b1, name, e0);
        @(negedge clk);
        startV[l] = 1'b0;
        waitIdle(l);
    endtask

    task automatic runLane(input int l);
        int n = NDIG_L[l];
        int e0;
        int k;

        @(negedge clk);
        rst = 1'b1;
        #1 checkOutput($sformatf("lane%0d reset state", l),
                       32'({busyV[l], doneV[l], coutV[l], sV[l]}), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        simpleOp(l, 20'd0, 20'd0, "zero");
        simpleOp(l, 20'hFFFFF, 20'd1, "wrap");
        simpleOp(l, 20'd110, 20'd110, "110+110");

        // Second start one cycle after acceptance must be ignored; old result stays visible.
        applyStimulus(l, 20'd72, 20'd27, 1'b1, "ignore restart", e0);
        @(negedge clk);
        checkOutput($sformatf("lane%0d busy after accept", l), 32'(busyV[l]), 32'd1);
        checkOutput($sformatf("lane%0d held result", l), 32'({coutV[l], sV[l]}), 32'd220);
        i0 = 20'd5;
        @(negedge clk);
        startV[l] = 1'b0;
        waitIdle(l);

        // Abort mid-run; start is held high while reset is asserted.
        applyStimulus(l, 20'd1000, 20'd24, 1'b0, "aborted", e0);
        @(negedge clk);
        startV[l] = 1'b0;
        k = (n > 2) ? 2 : n - 1;
        repeat (k) @(negedge clk);
        rst = 1'b1;
        startV[l] = 1'b1;
        #1 checkOutput($sformatf("lane%0d abort state", l),
                       32'({busyV[l], doneV[l], coutV[l], sV[l]}), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        startV[l] = 1'b0;
        @(negedge clk);
        checkOutput($sformatf("lane%0d idle after abort", l), 32'(busyV[l]), 32'd0);
        repeat (n + 3) @(negedge clk);
        simpleOp(l, 20'd3, 20'd4, "3+4");

        // Back-to-back: start held through the done cycle; operands change right after E0.
        applyStimulus(l, 20'd1, 20'd2, 1'b1, "b2b first", e0);
        @(negedge clk);
        i0 = 20'h80000;
        i1 = 20'h80000;
        scoreQ[l].push_back('{21'h100000, e0 + n + 1, "b2b second"});
        repeat (n + 1) @(negedge clk);
        startV[l] = 1'b0;
        waitIdle(l);
    endtask

    initial begin
        #2 rst = 1'b1;
        for (int l = 0; l < 3; l++) runLane(l);
        repeat (3) @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: got no completion, expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/twenty_bit_serial_adder.md
TWENTY_BIT_SERIAL_ADDER -- requirements
Module: twenty_bit_serial_adder

Interface
REQ-001 Parameter: DIGIT_W, 4, bits added per cycle; SHALL be one of 1, 2, 4, 5, 10, 20; NDIG = 20/DIGIT_W.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  request; sampled only when busy=0.
REQ-005 i0  input  20  augend, unsigned; sampled with start.
REQ-006 i1  input  20  addend, unsigned; sampled with start.
REQ-007 s  output  20  sum, i0+i1 mod 2^20.
REQ-008 cout  output  1  carry out of bit 19.
REQ-009 busy  output  1  high while an addition is in progress.
REQ-010 done  output  1  one-cycle pulse marking a new valid s/cout.

Function
REQ-011 States: IDLE and RUN, encoded 0/1.
REQ-012 IDLE with start=1 at edge E0: latch i0/i1 into operand shift registers; clear internal carry and digit counter; go to RUN; busy=1 from E0.
REQ-013 IDLE with start=0: hold state and all outputs.
REQ-014 RUN at edges E1..E_NDIG: add digit k (bits k*DIGIT_W up to k*DIGIT_W+DIGIT_W-1, LSB digit first) plus stored carry; store digit result and carry-out; increment counter.
REQ-015 At E_NDIG: load s and cout atomically from the accumulated result; busy=0; done=1 for exactly one cycle; return to IDLE.
REQ-016 Latency: done high in the cycle after edge E0+NDIG (5 cycles at DIGIT_W=4; 1 cycle at DIGIT_W=20).
REQ-017 s and cout SHALL hold the previous result throughout RUN and until the next E_NDIG; no partial values visible.
REQ-018 start while busy=1 SHALL be ignored; operands are not re-sampled.
REQ-019 start=1 in the done cycle (busy=0) SHALL be accepted; that edge is the new E0; back-to-back throughput is one result per NDIG+1 cycles.
REQ-020 Input changes on i0/i1 after E0 SHALL NOT affect the result.
REQ-021 Overflow wraps mod 2^20; cout=1 exactly when i0+i1 >= 2^20.

Reset
REQ-022 rst=1 SHALL force, without waiting for clk: state=IDLE, s=0, cout=0, busy=0, done=0, counter/carry/operand registers=0.
REQ-023 Reset during RUN SHALL abort the operation; no done pulse follows; the next start after rst falls begins a fresh addition.
REQ-024 start SHALL be ignored on any edge where rst=1.

Structure
REQ-025 Shared header twenty_bit_defs.vh SHALL hold WIDTH=20 and the IDLE/RUN state encodings; the subtractor family uses the same header.
REQ-026 One sub-module, digit_adder (DIGIT_W-bit ripple-carry add with cin/cout), SHALL be instantiated once; control FSM, counter and shift registers live in the top module.

Verification
REQ-027 i0=0, i1=0, start pulse -> done 5 cycles later, s=0, cout=0.
REQ-028 i0=20'hFFFFF, i1=1 -> s=0, cout=1; i0=20'd110, i1=20'd110 -> s=20'd220, cout=0.
REQ-029 i0=20'd72, i1=20'd27; change i0 to 5 and pulse start again one cycle after E0 -> second start ignored, single done, s=20'd99.
REQ-030 Assert rst 2 cycles into RUN of 20'd1000+20'd24 -> s=0, busy=0 immediately; no done; a following 3+4 gives s=7.
REQ-031 Back-to-back: start held high across done cycle with 1+2 then 20'h80000+20'h80000 -> s=3, cout=0, then s=0, cout=1, done pulses exactly 6 cycles apart.
REQ-032 Repeat REQ-027..REQ-031 for DIGIT_W=1 and DIGIT_W=20, scaling latency to NDIG, against a reference model i0+i1.
